tdm_demux8_rx: RTL

//  Receive end of an 8-slot time-division link whose transmit end is an 8:1 select-driven multiplexer.

---
 rtl/tdm_demux8_rx.sv | 107 ++++++++++
 1 files changed

// File: rtl/tdm_demux8_rx.sv
// Receive end of an 8-slot TDM link: aligns to the slot-0 marker, collects slots into a
// shadow frame, and publishes complete frames on dout with framing-error detection.
module tdm_demux8_rx #(
    parameter int WIDTH = 1,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [8*WIDTH-1:0]   dout,
    output logic                 frame_valid,
    output logic [7:0]           slot_strobe,
    output logic                 locked,
    output logic                 sync_err,
    output logic [ERR_W-1:0]     err_cnt
);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              slot, slot_nxt;
    logic [6:0][WIDTH-1:0]   shadow, shadow_nxt;
    logic [8*WIDTH-1:0]      dout_nxt;
    logic                    frame_valid_nxt;
    logic [7:0]              slot_strobe_nxt;
    logic                    sync_err_nxt;
    logic [ERR_W-1:0]        err_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= '0;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            slot_strobe <= '0;
            sync_err    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            shadow      <= shadow_nxt;
            dout        <= dout_nxt;
            frame_valid <= frame_valid_nxt;
            slot_strobe <= slot_strobe_nxt;
            sync_err    <= sync_err_nxt;
            err_cnt     <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        slot_nxt        = slot;
        shadow_nxt      = shadow;
        dout_nxt        = dout;
        frame_valid_nxt = 1'b0;
        slot_strobe_nxt = '0;
        sync_err_nxt    = 1'b0;

        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_nxt[0]   = din;
                        slot_nxt        = 3'd1;
                        slot_strobe_nxt = 8'h01;
                        state_nxt       = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // Early sync restarts the frame with this sample as slot 0.
                        sync_err_nxt    = (slot != 3'd0);
                        shadow_nxt[0]   = din;
                        slot_nxt        = 3'd1;
                        slot_strobe_nxt = 8'h01;
                    end else if (slot == 3'd0) begin
                        sync_err_nxt = 1'b1;
                        state_nxt    = HUNT;
                    end else begin
                        slot_strobe_nxt = 8'h01 << slot;
                        if (slot == 3'd7) begin
                            dout_nxt        = {din, shadow};
                            frame_valid_nxt = 1'b1;
                            slot_nxt        = 3'd0;
                        end else begin
                            shadow_nxt[slot] = din;
                            slot_nxt         = slot + 3'd1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        err_cnt_nxt = err_cnt;
        if (sync_err_nxt && (err_cnt != '1))
            err_cnt_nxt = err_cnt + ERR_W'(1);
    end

    assign locked = (state == LOCK);

endmodule
